// File: rtl/bitrev_reorder.sv
// ---------------------------------------------------------------------------
// bitrev_reorder
//   Converts frames of 2^N complex samples that arrive in bit-reversed order
//   (from the last FFT butterfly stage) into natural order.  Uses two
//   ping-pong banks: one is filled while the other drains, so back-to-back
//   frames stream through with a fixed latency of 2^N+1 cycles from start_ip
//   to start_op.
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start_ip  : one-cycle pulse alongside sample 0 of an input frame
//   ip_re     : real part of incoming sample (W bits, signed)
//   ip_im     : imaginary part of incoming sample (W bits, signed)
//   op_re     : real part of natural-order output sample (registered)
//   op_im     : imaginary part of output sample (registered)
//   op_valid  : high while op_re/op_im carry a valid sample
//   start_op  : one-cycle pulse alongside output index 0
//
// Write FSM
//   state  | meaning
//   W_IDLE | waiting for start_ip
//   W_FILL | capturing samples k=1..2^N-1 into the write bank
// Read FSM
//   state   | meaning
//   R_IDLE  | no frame to drain
//   R_DRAIN | reading read-bank addresses m=0..2^N-1
// ---------------------------------------------------------------------------
module bitrev_reorder #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_ip,
  input  logic [W-1:0] ip_re,
  input  logic [W-1:0] ip_im,
  output logic [W-1:0] op_re,
  output logic [W-1:0] op_im,
  output logic         op_valid,
  output logic         start_op
);

  localparam int             DEPTH  = 1 << N;
  localparam logic [N-1:0]   K_LAST = '1;

  typedef enum logic {W_IDLE, W_FILL}  w_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = a[N-1-i];
    return r;
  endfunction

  // Two banks flattened into one array; the MSB of the address is the bank.
  logic [W-1:0] mem_re [2*DEPTH];
  logic [W-1:0] mem_im [2*DEPTH];

  w_state_t     w_state, w_state_nxt;
  logic [N-1:0] wr_k, wr_k_nxt;
  logic         bank_sel, bank_sel_nxt;
  logic [N-1:0] wr_k_eff;
  logic [N-1:0] wr_addr;
  logic         wr_en;
  logic         frame_done;

  r_state_t     r_state, r_state_nxt;
  logic [N-1:0] rd_m, rd_m_nxt;
  logic         rd_en;
  logic [N:0]   rd_addr;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      wr_k     <= '0;
      bank_sel <= 1'b0;
    end else begin
      w_state  <= w_state_nxt;
      wr_k     <= wr_k_nxt;
      bank_sel <= bank_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = w_state;
    wr_k_nxt     = wr_k;
    bank_sel_nxt = bank_sel;
    if (wr_en) begin
      if (frame_done) begin
        w_state_nxt  = W_IDLE;
        wr_k_nxt     = '0;
        bank_sel_nxt = ~bank_sel;
      end else begin
        w_state_nxt = W_FILL;
        wr_k_nxt    = wr_k_eff + N'(1);
      end
    end
  end

  // start_ip always restarts the count at 0 in the current write bank; the
  // sample presented with it is sample 0, so it is written in that cycle.
  always_comb begin
    wr_k_eff   = start_ip ? '0 : wr_k;
    wr_en      = start_ip || (w_state == W_FILL);
    frame_done = wr_en && (wr_k_eff == K_LAST);
    wr_addr    = bitrev(wr_k_eff);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_re[{bank_sel, wr_addr}] <= ip_re;
      mem_im[{bank_sel, wr_addr}] <= ip_im;
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      rd_m    <= '0;
    end else begin
      r_state <= r_state_nxt;
      rd_m    <= rd_m_nxt;
    end
  end

  // A new frame can only complete on or after the last drain cycle of the
  // previous one, so frame_done is only examined in R_IDLE or at m = last.
  always_comb begin
    r_state_nxt = r_state;
    rd_m_nxt    = rd_m;
    case (r_state)
      R_IDLE: begin
        if (frame_done) begin
          r_state_nxt = R_DRAIN;
          rd_m_nxt    = '0;
        end
      end
      R_DRAIN: begin
        if (rd_m == K_LAST) begin
          rd_m_nxt    = '0;
          r_state_nxt = frame_done ? R_DRAIN : R_IDLE;
        end else begin
          rd_m_nxt = rd_m + N'(1);
        end
      end
      default: begin
        r_state_nxt = R_IDLE;
        rd_m_nxt    = '0;
      end
    endcase
  end

  always_comb begin
    rd_en   = (r_state == R_DRAIN);
    rd_addr = {~bank_sel, rd_m};
  end

  // Output register; data holds its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_re    <= '0;
      op_im    <= '0;
      op_valid <= 1'b0;
      start_op <= 1'b0;
    end else begin
      op_valid <= rd_en;
      start_op <= rd_en && (rd_m == '0);
      if (rd_en) begin
        op_re <= mem_re[rd_addr];
        op_im <= mem_im[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_bitrev_reorder.sv
module tb_bitrev_reorder;

  logic        clk;
  logic        rst_n;
  logic        start_ip;
  logic [15:0] ip_re;
  logic [15:0] ip_im;
  logic [15:0] op_re;
  logic [15:0] op_im;
  logic        op_valid;
  logic        start_op;

  int total = 0;
  int bad   = 0;

  bitrev_reorder #(.N(3), .W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_ip (start_ip),
    .ip_re    (ip_re),
    .ip_im    (ip_im),
    .op_re    (op_re),
    .op_im    (op_im),
    .op_valid (op_valid),
    .start_op (start_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // natural index m -> arrival index that lands there (3-bit reversal)
  logic [15:0] br_tab [8] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};

  int          cyc;
  logic        lv  [0:63];
  logic        ls  [0:63];
  logic [15:0] lre [0:63];
  logic [15:0] lim [0:63];

  task automatic run_cycle(input logic s, input logic [15:0] re, input logic [15:0] im);
    start_ip = s;
    ip_re    = re;
    ip_im    = im;
    @(posedge clk);
    #1;
    cyc++;
    lv[cyc]  = op_valid;
    ls[cyc]  = start_op;
    lre[cyc] = op_re;
    lim[cyc] = op_im;
    start_ip = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_ip = 1'b0; ip_re = '0; ip_im = '0;
    #3;
    total++;
    if (op_valid !== 1'b0 || start_op !== 1'b0 || op_re !== 16'h0 || op_im !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b s=%b re=%h im=%h want all zero", op_valid, start_op, op_re, op_im);
    end
    @(posedge clk); #1;
    total++;
    if (op_valid !== 1'b0 || op_re !== 16'h0) begin
      bad++;
      $display("FAIL reset_hold: got v=%b re=%h want 0 0", op_valid, op_re);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    cyc = 0;
    for (int k = 0; k < 8; k++) run_cycle(k == 0, 16'(k), 16'd0 - 16'(k));
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 16'h0, 16'h0);
    for (int c = 1; c <= 20; c++) begin
      total++;
      if (lv[c] !== (c >= 9 && c <= 16) || ls[c] !== (c == 9)) begin
        bad++;
        $display("FAIL single_ctrl[%0d]: got v=%b s=%b want v=%b s=%b", c, lv[c], ls[c], (c >= 9 && c <= 16), (c == 9));
      end
    end
    for (int j = 0; j < 8; j++) begin
      total++;
      if (lre[9+j] !== br_tab[j] || lim[9+j] !== 16'd0 - br_tab[j]) begin
        bad++;
        $display("FAIL single_data[%0d]: got %h/%h want %h/%h", j, lre[9+j], lim[9+j], br_tab[j], 16'd0 - br_tab[j]);
      end
    end
    for (int c = 17; c <= 20; c++) begin
      total++;
      if (lre[c] !== 16'd7 || lim[c] !== 16'hFFF9) begin
        bad++;
        $display("FAIL idle_hold[%0d]: got %h/%h want 0007/fff9", c, lre[c], lim[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc = 0;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 8; k++) run_cycle(k == 0, 16'(8*f+k), 16'd0 - 16'(8*f+k));
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 16'h0, 16'h0);
    for (int c = 1; c <= 36; c++) begin
      total++;
      if (lv[c] !== (c >= 9 && c <= 32) || ls[c] !== (c == 9 || c == 17 || c == 25)) begin
        bad++;
        $display("FAIL b2b_ctrl[%0d]: got v=%b s=%b want v=%b s=%b", c, lv[c], ls[c],
                 (c >= 9 && c <= 32), (c == 9 || c == 17 || c == 25));
      end
    end
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < 8; j++) begin
        total++;
        if (lre[9+8*f+j] !== 16'(8*f) + br_tab[j] || lim[9+8*f+j] !== 16'd0 - (16'(8*f) + br_tab[j])) begin
          bad++;
          $display("FAIL b2b_data[f%0d,%0d]: got %h/%h want %h/%h", f, j, lre[9+8*f+j], lim[9+8*f+j],
                   16'(8*f) + br_tab[j], 16'd0 - (16'(8*f) + br_tab[j]));
        end
      end
  endtask

  task automatic test_restart();
    cyc = 0;
    for (int k = 0; k < 5; k++) run_cycle(k == 0, 16'(100+k), 16'(200+k));
    for (int k = 0; k < 8; k++) run_cycle(k == 0, 16'(k), 16'd0 - 16'(k));
    for (int i = 0; i < 12; i++) run_cycle(1'b0, 16'h0, 16'h0);
    for (int c = 1; c <= 25; c++) begin
      total++;
      if (lv[c] !== (c >= 14 && c <= 21) || ls[c] !== (c == 14)) begin
        bad++;
        $display("FAIL restart_ctrl[%0d]: got v=%b s=%b want v=%b s=%b", c, lv[c], ls[c], (c >= 14 && c <= 21), (c == 14));
      end
    end
    for (int j = 0; j < 8; j++) begin
      total++;
      if (lre[14+j] !== br_tab[j] || lim[14+j] !== 16'd0 - br_tab[j]) begin
        bad++;
        $display("FAIL restart_data[%0d]: got %h/%h want %h/%h", j, lre[14+j], lim[14+j], br_tab[j], 16'd0 - br_tab[j]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    cyc = 0;
    for (int k = 0; k < 8; k++) run_cycle(k == 0, 16'(k+1), 16'(k+1));
    for (int i = 0; i < 3; i++) run_cycle(1'b0, 16'h0, 16'h0);
    total++;
    if (lv[11] !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_valid: got %b want 1", lv[11]);
    end
    rst_n = 1'b0;
    #2;
    total++;
    if (op_valid !== 1'b0 || start_op !== 1'b0 || op_re !== 16'h0 || op_im !== 16'h0) begin
      bad++;
      $display("FAIL async_reset: got v=%b s=%b re=%h im=%h want all zero", op_valid, start_op, op_re, op_im);
    end
    #1 rst_n = 1'b1;
    cyc = 0;
    for (int i = 0; i < 15; i++) run_cycle(1'b0, 16'h0, 16'h0);
    for (int c = 1; c <= 15; c++) begin
      total++;
      if (lv[c] !== 1'b0 || ls[c] !== 1'b0 || lre[c] !== 16'h0) begin
        bad++;
        $display("FAIL post_reset_quiet[%0d]: got v=%b s=%b re=%h want 0 0 0000", c, lv[c], ls[c], lre[c]);
      end
    end
    cyc = 0;
    for (int k = 0; k < 8; k++) run_cycle(k == 0, 16'(32+k), 16'(k));
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 16'h0, 16'h0);
    for (int c = 1; c <= 18; c++) begin
      total++;
      if (lv[c] !== (c >= 9 && c <= 16) || ls[c] !== (c == 9)) begin
        bad++;
        $display("FAIL post_reset_ctrl[%0d]: got v=%b s=%b want v=%b s=%b", c, lv[c], ls[c], (c >= 9 && c <= 16), (c == 9));
      end
    end
    for (int j = 0; j < 8; j++) begin
      total++;
      if (lre[9+j] !== 16'd32 + br_tab[j] || lim[9+j] !== br_tab[j]) begin
        bad++;
        $display("FAIL post_reset_data[%0d]: got %h/%h want %h/%h", j, lre[9+j], lim[9+j], 16'd32 + br_tab[j], br_tab[j]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [15:0] in_re  [8] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000};
    logic [15:0] in_im  [8] = '{16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000};
    logic [15:0] exp_re [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] exp_im [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
    cyc = 0;
    for (int k = 0; k < 8; k++) run_cycle(k == 0, in_re[k], in_im[k]);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 16'h0, 16'h0);
    for (int j = 0; j < 8; j++) begin
      total++;
      if (lv[9+j] !== 1'b1 || lre[9+j] !== exp_re[j] || lim[9+j] !== exp_im[j]) begin
        bad++;
        $display("FAIL extreme[%0d]: got v=%b %h/%h want v=1 %h/%h", j, lv[9+j], lre[9+j], lim[9+j], exp_re[j], exp_im[j]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_restart();
    test_reset_mid_drain();
    test_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitrev_reorder.md
BITREV_REORDER -- requirements
Module: bitrev_reorder

Interface
REQ-001 SHALL have parameter N, default 3, meaning log2 of the frame length; frame = 2^N complex samples.
REQ-002 SHALL have parameter W, default 16, meaning signed two's-complement width of each real and imaginary part.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port start_ip, input, 1 bit, high for one cycle alongside sample 0 of a frame from the last butterfly stage.
REQ-006 SHALL have port ip_re, input, W bits, real part of the incoming bit-reversed-order sample.
REQ-007 SHALL have port ip_im, input, W bits, imaginary part of the incoming sample.
REQ-008 SHALL have port op_re, output, W bits, real part of the natural-order output sample, registered.
REQ-009 SHALL have port op_im, output, W bits, imaginary part of the output sample, registered.
REQ-010 SHALL have port op_valid, output, 1 bit, high while op_re/op_im carry a valid sample.
REQ-011 SHALL have port start_op, output, 1 bit, high for one cycle alongside natural-order output index 0.

Function
REQ-012 SHALL hold two banks of 2^N complex words (ping-pong); the write bank and the read bank are always different.
REQ-013 SHALL run a write FSM with states W_IDLE and W_FILL; start_ip high in any state moves to W_FILL with write count k = 0.
REQ-014 SHALL, in W_FILL, capture the sample at count k into write-bank address bitrev_N(k), one sample per cycle, no gaps, no backpressure.
REQ-015 SHALL, after capturing k = 2^N-1, swap banks, signal frame-complete to the read FSM, and return to W_IDLE unless start_ip is high that cycle.
REQ-016 SHALL run a read FSM with states R_IDLE and R_DRAIN; frame-complete moves it to R_DRAIN with read index m = 0.
REQ-017 SHALL, in R_DRAIN, read read-bank address m for m = 0..2^N-1, one per cycle, then return to R_IDLE.
REQ-018 SHALL make the latency from the start_ip cycle to the start_op cycle exactly 2^N+1 cycles; op_valid then stays high for exactly 2^N consecutive cycles.
REQ-019 SHALL assert start_op only with m = 0 output; op_valid and start_op are low in all other cycles.
REQ-020 SHALL hold op_re/op_im at their last value when op_valid is low.
REQ-021 SHALL pass data unmodified: no scaling, rounding or sign change.
REQ-022 SHALL support back-to-back frames: start_ip in the cycle after sample 2^N-1 fills the other bank while the previous frame drains, with no lost or duplicated output.
REQ-023 SHALL treat start_ip during W_FILL with k > 0 as an abort: the partial frame is discarded, k restarts at 0 in the same write bank, no bank swap occurs, and any drain in progress is unaffected.
REQ-024 SHALL, when frame-complete coincides with the final R_DRAIN cycle, output the last sample of the old frame and then start the new drain in the next cycle with no gap.
REQ-025 SHALL compute bitrev_N(k) by reversing the N address bits; N = 1 degenerates to identity ordering.

Reset
REQ-026 SHALL, while rst_n is low, force W_IDLE, R_IDLE, k = 0, m = 0, bank select = 0, op_re = 0, op_im = 0, op_valid = 0, start_op = 0, regardless of clk.
REQ-027 SHALL, on reset mid-frame or mid-drain, discard all partial and pending frames; the first start_ip after rst_n deasserts behaves as the first frame after power-up.
REQ-028 SHALL NOT reset bank contents; they are unobservable until overwritten.

Verification
REQ-029 SHALL verify, with N=3 and ip_re = k, ip_im = -k for arrival k = 0..7: start_op 9 cycles after start_ip, then op_re = 0,4,2,6,1,5,3,7 and op_im the negations, op_valid high for exactly 8 cycles.
REQ-030 SHALL verify three back-to-back frames (ip_re = 8f+k): 24 contiguous op_valid cycles, three start_op pulses 8 cycles apart, each frame correctly reordered.
REQ-031 SHALL verify a restart, start_ip at k = 5 then a full frame: only the second frame appears at the output, start_op 9 cycles after the second start_ip.
REQ-032 SHALL verify rst_n pulsed low mid-drain: op_valid = 0 and op_re = op_im = 0 immediately without a clock edge, with no further output until a new frame is received.
REQ-033 SHALL verify extreme values at W=16: inputs 0x7FFF and 0x8000 emerge bit-exact at the bit-reversed positions.
REQ-034 SHALL verify a single frame followed by idle: after 8 outputs, op_valid stays low and op_re/op_im hold the value 7 indefinitely.
